// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencer: merges redirect, load-use, imem wait and halt into IF/ID/EX controls.
// Mealy outputs (zero-cycle) from RUN/FLUSH/HALT state; bubble counter visible one cycle later.
module fetch_hazard_ctrl #(
  parameter int BW        = 32,
  parameter int FLUSH_CYC = 1,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_req,
  input  logic [BW-1:0] br_target,
  input  logic          ld_use,
  input  logic          mem_wait,
  input  logic          halt_req,
  input  logic          resume,
  output logic          btaken,
  output logic [BW-1:0] EXE_in,
  output logic          stall,
  output logic          flush_id,
  output logic          flush_ex,
  output logic          halted,
  output logic [CW-1:0] bubble_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  localparam logic [2:0] FC = 3'(FLUSH_CYC);

  state_t        state_q, state_d;
  logic [2:0]    fcnt_q, fcnt_d;
  logic [CW-1:0] cnt_q;
  logic          bubble;

  always_comb begin
    btaken   = 1'b0;
    EXE_in   = '0;
    stall    = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    halted   = 1'b0;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    if (!rst) begin
      // A redirect from EXE wins in RUN and restarts an ongoing FLUSH.
      if (br_req && (state_q != HALT)) begin
        btaken   = 1'b1;
        EXE_in   = br_target;
        flush_id = 1'b1;
        flush_ex = 1'b1;
        fcnt_d   = FC;
        state_d  = (FC != 3'd0) ? FLUSH : RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (halt_req) begin
              stall    = 1'b1;
              flush_id = 1'b1;
              state_d  = HALT;
            end else if (mem_wait) begin
              stall    = 1'b1;
              flush_id = 1'b1;
            end else if (ld_use) begin
              stall    = 1'b1;
              flush_ex = 1'b1;
            end
          end
          FLUSH: begin
            // Wrong-path ld_use/halt_req are ignored; mem_wait freezes the countdown.
            flush_id = 1'b1;
            stall    = mem_wait;
            if (!mem_wait) begin
              fcnt_d = fcnt_q - 3'd1;
              if (fcnt_q <= 3'd1) state_d = RUN;
            end
          end
          HALT: begin
            stall    = 1'b1;
            flush_id = 1'b1;
            halted   = 1'b1;
            if (resume) state_d = RUN;
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  assign bubble     = stall | flush_id | flush_ex;
  assign bubble_cnt = rst ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (bubble && (cnt_q != {CW{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
